// File: rtl/rtc_hms_counter.sv
// BCD hours:minutes:seconds time-of-day counter driven by a 1 Hz tick.
// Provides second/midnight strobes and a freeze-and-increment set mode.
module rtc_hms_counter #(
  parameter int EDGE_DETECT = 1,
  parameter int INIT_HH     = 0,
  parameter int INIT_MM     = 0,
  parameter int INIT_SS     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic       set_inc,
  output logic [3:0] hh_t,
  output logic [3:0] hh_o,
  output logic [3:0] mm_t,
  output logic [3:0] mm_o,
  output logic [3:0] ss_t,
  output logic [3:0] ss_o,
  output logic       sec_pulse,
  output logic       day_pulse
);

  localparam logic [7:0] INIT_H = {4'(INIT_HH / 10), 4'(INIT_HH % 10)};
  localparam logic [7:0] INIT_M = {4'(INIT_MM / 10), 4'(INIT_MM % 10)};
  localparam logic [7:0] INIT_S = {4'(INIT_SS / 10), 4'(INIT_SS % 10)};

  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       tick_d;

  logic [7:0] hh_n;
  logic [7:0] mm_n;
  logic [7:0] ss_n;
  logic       sec_n;
  logic       day_n;
  logic       adv;

  function automatic logic [7:0] inc60(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h59)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] inc24(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign adv = (EDGE_DETECT != 0) ? (tick_in & ~tick_d) : tick_in;

  // Next-time selection: tick advance with carries, or a set-mode field bump.
  always_comb begin
    hh_n  = hh;
    mm_n  = mm;
    ss_n  = ss;
    sec_n = 1'b0;
    day_n = 1'b0;
    if (!set_en) begin
      if (adv) begin
        sec_n = 1'b1;
        ss_n  = inc60(ss);
        if (ss == 8'h59) begin
          mm_n = inc60(mm);
          if (mm == 8'h59) begin
            hh_n  = inc24(hh);
            day_n = (hh == 8'h23);
          end
        end
      end
    end else if (set_inc) begin
      case (set_sel)
        2'b00:   ss_n = inc60(ss);
        2'b01:   mm_n = inc60(mm);
        2'b10:   hh_n = inc24(hh);
        default: ;
      endcase
    end
  end

  // Time, strobe and tick-history registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hh        <= INIT_H;
      mm        <= INIT_M;
      ss        <= INIT_S;
      tick_d    <= 1'b1;
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
    end else begin
      hh        <= hh_n;
      mm        <= mm_n;
      ss        <= ss_n;
      tick_d    <= tick_in;
      sec_pulse <= sec_n;
      day_pulse <= day_n;
    end
  end

  assign hh_t = hh[7:4];
  assign hh_o = hh[3:0];
  assign mm_t = mm[7:4];
  assign mm_o = mm[3:0];
  assign ss_t = ss[7:4];
  assign ss_o = ss[3:0];

endmodule

// File: tb/tb_rtc_hms_counter.sv
// Directed bench for rtc_hms_counter: one edge-detect and one
// strobe-mode instance, expected values worked out by hand.
module tb_rtc_hms_counter;

  logic       clk;
  logic       rst;
  logic       tick_in;
  logic       set_en;
  logic [1:0] set_sel;
  logic       set_inc;
  logic [3:0] hh_t, hh_o, mm_t, mm_o, ss_t, ss_o;
  logic       sec_pulse, day_pulse;

  logic       rst0;
  logic       tick0;
  logic [3:0] hh_t0, hh_o0, mm_t0, mm_o0, ss_t0, ss_o0;
  logic       sec_pulse0, day_pulse0;

  int vectors;
  int miscompares;
  int sec_cnt;
  int day_cnt;
  int slot_cnt;

  rtc_hms_counter #(.EDGE_DETECT(1)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in),
    .set_en(set_en), .set_sel(set_sel), .set_inc(set_inc),
    .hh_t(hh_t), .hh_o(hh_o), .mm_t(mm_t), .mm_o(mm_o),
    .ss_t(ss_t), .ss_o(ss_o),
    .sec_pulse(sec_pulse), .day_pulse(day_pulse)
  );

  rtc_hms_counter #(.EDGE_DETECT(0)) dut0 (
    .clk(clk), .rst(rst0), .tick_in(tick0),
    .set_en(1'b0), .set_sel(2'b11), .set_inc(1'b0),
    .hh_t(hh_t0), .hh_o(hh_o0), .mm_t(mm_t0), .mm_o(mm_o0),
    .ss_t(ss_t0), .ss_o(ss_o0),
    .sec_pulse(sec_pulse0), .day_pulse(day_pulse0)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic logic [31:0] now();
    return {8'h0, hh_t, hh_o, mm_t, mm_o, ss_t, ss_o};
  endfunction

  function automatic logic [31:0] now0();
    return {8'h0, hh_t0, hh_o0, mm_t0, mm_o0, ss_t0, ss_o0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    sec_cnt += int'(sec_pulse);
    day_cnt += int'(day_pulse);
  endtask

  task automatic clr();
    sec_cnt = 0;
    day_cnt = 0;
  endtask

  task automatic sq();
    tick_in = 1'b1;
    step();
    slot_cnt += int'(sec_pulse);
    repeat (3) step();
    tick_in = 1'b0;
    repeat (4) step();
  endtask

  task automatic bump(input logic [1:0] sel, input int n);
    set_sel = sel;
    set_inc = 1'b1;
    repeat (n) step();
    set_inc = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    slot_cnt = 0;
    clr();
    rst = 1'b0; rst0 = 1'b0;
    tick_in = 1'b1; tick0 = 1'b0;
    set_en = 1'b0; set_sel = 2'b11; set_inc = 1'b0;

    // 1: reset with tick held high
    repeat (2) step();
    rst = 1'b1; rst0 = 1'b1;
    step();
    chk("rst_time", now(), 32'h000000);
    chk("rst_sec", {31'h0, sec_pulse}, 32'h0);
    chk("rst_day", {31'h0, day_pulse}, 32'h0);
    clr();
    repeat (5) step();
    chk("rst_hold_time", now(), 32'h000000);
    chk("rst_hold_sec", sec_cnt, 0);

    // 2: 60 square-wave edges
    tick_in = 1'b0;
    repeat (4) step();
    clr();
    slot_cnt = 0;
    sq();
    chk("first_edge", now(), 32'h000001);
    repeat (59) sq();
    chk("count_time", now(), 32'h000100);
    chk("count_sec", sec_cnt, 60);
    chk("count_slot", slot_cnt, 60);

    // 3: midnight rollover
    set_en = 1'b1;
    bump(2'b10, 23);
    bump(2'b01, 58);
    bump(2'b00, 58);
    set_en = 1'b0;
    step();
    chk("set_235958", now(), 32'h235958);
    clr();
    tick_in = 1'b1;
    step();
    chk("r1_time", now(), 32'h235959);
    chk("r1_strobe", {30'h0, sec_pulse, day_pulse}, 32'h2);
    repeat (3) step();
    tick_in = 1'b0;
    repeat (4) step();
    tick_in = 1'b1;
    step();
    chk("r2_time", now(), 32'h000000);
    chk("r2_strobe", {30'h0, sec_pulse, day_pulse}, 32'h3);
    step();
    chk("r2_after", {30'h0, sec_pulse, day_pulse}, 32'h0);
    chk("r_day_cnt", day_cnt, 1);
    tick_in = 1'b0;
    repeat (4) step();

    // 4: set-mode wraps without carry, ticks discarded
    set_en = 1'b1;
    bump(2'b10, 23);
    bump(2'b01, 59);
    bump(2'b00, 30);
    step();
    chk("set_235930", now(), 32'h235930);
    bump(2'b10, 1);
    step();
    chk("wrap_hh", now(), 32'h005930);
    bump(2'b01, 1);
    step();
    chk("wrap_mm", now(), 32'h000030);
    bump(2'b11, 3);
    step();
    chk("sel_none", now(), 32'h000030);
    clr();
    repeat (5) sq();
    chk("frozen_time", now(), 32'h000030);
    chk("frozen_str", sec_cnt + day_cnt, 0);
    set_en = 1'b0;
    bump(2'b00, 3);
    step();
    chk("inc_ignored", now(), 32'h000030);
    sq();
    chk("resume", now(), 32'h000031);

    // 5: held tick, edge-detect vs strobe mode
    clr();
    tick_in = 1'b1;
    tick0 = 1'b1;
    repeat (100) step();
    tick_in = 1'b0;
    tick0 = 1'b0;
    chk("held_edge_cnt", sec_cnt, 1);
    chk("held_edge_time", now(), 32'h000032);
    chk("held_lvl_time", now0(), 32'h000140);
    step();
    chk("held_lvl_idle", {31'h0, sec_pulse0}, 32'h0);

    // 6: reset mid-operation
    set_en = 1'b1;
    bump(2'b10, 12);
    bump(2'b01, 34);
    bump(2'b00, 24);
    set_en = 1'b0;
    repeat (4) step();
    chk("set_123456", now(), 32'h123456);
    rst = 1'b0;
    tick_in = 1'b1;
    set_inc = 1'b1;
    set_sel = 2'b00;
    step();
    rst = 1'b1;
    set_inc = 1'b0;
    chk("mid_rst_time", now(), 32'h000000);
    chk("mid_rst_sec", {31'h0, sec_pulse}, 32'h0);
    clr();
    repeat (3) step();
    chk("mid_rst_hold", sec_cnt, 0);
    tick_in = 1'b0;
    repeat (4) step();
    tick_in = 1'b1;
    step();
    chk("mid_rst_resume", now(), 32'h000001);
    chk("mid_rst_pulse", {31'h0, sec_pulse}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rtc_hms_counter.md
Name: rtc_hms_counter

Overview:
Time-of-day counter that consumes the 1 Hz square wave produced by the 50 MHz-to-1 Hz divider. It sits directly downstream of that divider and upstream of the seven-segment/LED display drivers. It keeps hours:minutes:seconds in BCD (24-hour), emits one-cycle second and midnight strobes, and provides a freeze-and-increment set mode for board push-buttons that are debounced upstream.

Parameters:
EDGE_DETECT, 1, 1: tick_in is a square wave and the counter advances on its rising edge; 0: tick_in is a one-cycle strobe and the counter advances on every cycle it is high
INIT_HH, 0, hour loaded at reset, 0-23, binary
INIT_MM, 0, minute loaded at reset, 0-59, binary
INIT_SS, 0, second loaded at reset, 0-59, binary

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-low
tick_in  in  1  1 Hz tick from the divider, synchronous to clk
set_en  in  1  1 = set mode: time advance is frozen
set_sel  in  2  field select: 00 = seconds, 01 = minutes, 10 = hours, 11 = none
set_inc  in  1  increments the selected field on each cycle it is high, only while set_en = 1
hh_t  out  4  hours tens digit, BCD, 0-2
hh_o  out  4  hours ones digit, BCD
mm_t  out  4  minutes tens digit, BCD, 0-5
mm_o  out  4  minutes ones digit, BCD
ss_t  out  4  seconds tens digit, BCD, 0-5
ss_o  out  4  seconds ones digit, BCD
sec_pulse  out  1  one-cycle strobe on every time advance
day_pulse  out  1  one-cycle strobe on the 23:59:59 -> 00:00:00 rollover

Behaviour:
- Single clock domain. Every state change happens on a rising clk edge. All outputs are registered.
- Reset:
  - rst = 0 sampled at an edge loads the digits with the BCD of INIT_HH:INIT_MM:INIT_SS.
  - sec_pulse = 0 and day_pulse = 0.
  - The tick_d history register is loaded with 1. A tick_in that is already high at reset release therefore does not advance the time.
  - Reset overrides all other inputs.
- Advance condition, adv:
  - EDGE_DETECT = 1: adv = tick_in & ~tick_d, where tick_d is tick_in registered every cycle.
  - EDGE_DETECT = 0: adv = tick_in.
  - adv counts only when set_en = 0.
- Advance latency:
  - Digits update on the same edge that samples adv = 1.
  - The new value is visible in the cycle after tick_in is first sampled high.
  - sec_pulse is high for exactly that one cycle, aligned with the new value.
- Carry chain, all BCD:
  - ss_o 9 -> 0 carries into ss_t.
  - ss 59 -> 00 carries into minutes; mm 59 -> 00 carries into hours.
  - hh 09 -> 10 and 19 -> 20 are ordinary BCD carries.
  - 23 -> 00 is the wrap.
  - 23:59:59 -> 00:00:00 asserts day_pulse for one cycle, coincident with sec_pulse.
- Set mode (set_en = 1):
  - Ticks are discarded, not queued. tick_d keeps tracking tick_in, so no burst occurs on exit.
  - sec_pulse and day_pulse stay 0.
  - set_inc = 1 increments the selected field by 1 modulo its range: seconds 60, minutes 60, hours 24.
  - No carry into the neighbouring field. day_pulse is never asserted by a set.
  - set_sel = 11 ignores set_inc.
- set_inc while set_en = 0 is ignored.
- Leaving set mode: counting resumes on the next qualifying adv. The seconds value is kept; no implicit zeroing.
- Digit invariants: digits never leave their BCD range. Unused upper bits of the tens digits are always 0.
- Illegal INIT_* values (above range) are unsupported. The bench checks only legal values.

Test Plan:
1. Reset: rst = 0 for 2 cycles with tick_in = 1, then release -> 00:00:00, sec_pulse = 0, day_pulse = 0, and no advance while tick_in stays high.
2. Normal count: tick_in square wave with period 8 clk, 60 rising edges -> time reads 00:01:00, exactly 60 sec_pulse cycles, each 1 cycle wide, 1 cycle after each rising edge.
3. Midnight rollover:
   - Use set mode to reach 23:59:58, release set_en, apply 2 edges.
   - Expect 23:59:59, then 00:00:00.
   - day_pulse is exactly 1 cycle, coincident with the second sec_pulse.
4. Set-mode wrap with no carry:
   - At 23:59:30, with set_en = 1 and set_sel = 10, pulse set_inc once -> 00:59:30.
   - set_sel = 01, pulse once -> 00:00:30.
   - 5 tick edges during set mode -> no change, no strobes.
5. Held tick: tick_in held high for 100 cycles with EDGE_DETECT = 1 -> exactly one advance. With EDGE_DETECT = 0 -> 100 advances, e.g. 00:00:00 -> 00:01:40.
6. Reset mid-operation: at 12:34:56, assert rst = 0 for 1 cycle coincident with a tick edge and set_inc -> 00:00:00 on the next cycle, no sec_pulse, and counting resumes on the next edge.
